// File: rtl/conv_pkg.sv
// conv_pkg: widths and FSM state type shared by the 3x3 window generator.
`default_nettype none

package conv_pkg;
  localparam int PIX_W    = 8;
  localparam int WIN_TAPS = 9;
  localparam int WIN_W    = PIX_W * WIN_TAPS;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;
endpackage

`default_nettype wire

// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: pixel stream in, 3x3 window stream out.
`default_nettype none

interface conv_window_gen_if;
  import conv_pkg::*;

  logic             in_valid;
  logic             in_sof;
  logic [PIX_W-1:0] pixel_in;
  logic [WIN_W-1:0] window;
  logic             win_valid;
  logic             win_last;
  logic             busy;

  modport master (
    output in_valid, in_sof, pixel_in,
    input  window, win_valid, win_last, busy
  );

  modport slave (
    input  in_valid, in_sof, pixel_in,
    output window, win_valid, win_last, busy
  );
endinterface

`default_nettype wire

// File: rtl/line_buf.sv
// line_buf: one image line of pixels; combinational read returns the old
// value at addr in the same cycle it is overwritten.
`default_nettype none

module line_buf
  import conv_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  input  logic             we,
  input  logic [PIX_W-1:0] wr_data,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv_window_gen.sv
// conv_window_gen: raster pixel stream to registered 3x3 windows, emitted
// only for pixels with a full neighbourhood (valid-only convolution).
`default_nettype none

module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8
) (
  input  logic             clk,
  input  logic             rstn_,
  conv_window_gen_if.slave px
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    col_q, col_d, col_cur;
  logic [RW-1:0]    row_q, row_d, row_cur;
  logic             sof_hit, accept, at_last, strobe;
  logic [PIX_W-1:0] l1_rd, l2_rd;
  logic [PIX_W-1:0] sr_q [2][3];
  logic [WIN_W-1:0] win_d, win_q;
  logic             win_valid_q, win_last_q;

  always_ff @(posedge clk or negedge rstn_) begin
    if (!rstn_) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // An sof pixel is position (0,0) regardless of where the counters stand.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    sof_hit = px.in_valid && px.in_sof;
    accept  = px.in_valid && (px.in_sof || state_q == RUN);
    col_cur = sof_hit ? '0 : col_q;
    row_cur = sof_hit ? '0 : row_q;
    at_last = (row_cur == R_LAST) && (col_cur == C_LAST);
    strobe  = accept && (row_cur >= RW'(2)) && (col_cur >= CW'(2));
    if (accept) begin
      state_d = at_last ? IDLE : RUN;
      if (col_cur == C_LAST) begin
        col_d = '0;
        row_d = (row_cur == R_LAST) ? '0 : row_cur + RW'(1);
      end else begin
        col_d = col_cur + CW'(1);
        row_d = row_cur;
      end
    end
  end

  line_buf #(.DEPTH(IMG_W), .AW(CW)) u_line1 (
    .clk     (clk),
    .addr    (col_cur),
    .we      (accept),
    .wr_data (px.pixel_in),
    .rd_data (l1_rd)
  );

  line_buf #(.DEPTH(IMG_W), .AW(CW)) u_line2 (
    .clk     (clk),
    .addr    (col_cur),
    .we      (accept),
    .wr_data (l1_rd),
    .rd_data (l2_rd)
  );

  // Columns b=0,1 come from the shift register, b=2 is the live column.
  always_comb begin
    win_d = '0;
    for (int a = 0; a < 3; a++) begin
      win_d[(3*a)*PIX_W +: PIX_W]     = sr_q[0][a];
      win_d[(3*a + 1)*PIX_W +: PIX_W] = sr_q[1][a];
    end
    win_d[2*PIX_W +: PIX_W] = l2_rd;
    win_d[5*PIX_W +: PIX_W] = l1_rd;
    win_d[8*PIX_W +: PIX_W] = px.pixel_in;
  end

  always_ff @(posedge clk or negedge rstn_) begin
    if (!rstn_) begin
      col_q       <= '0;
      row_q       <= '0;
      sr_q        <= '{default: '0};
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= strobe;
      win_last_q  <= strobe && at_last;
      if (accept) begin
        sr_q[0]    <= sr_q[1];
        sr_q[1][0] <= l2_rd;
        sr_q[1][1] <= l1_rd;
        sr_q[1][2] <= px.pixel_in;
      end
      if (strobe) begin
        win_q <= win_d;
      end
    end
  end

  assign px.window    = win_q;
  assign px.win_valid = win_valid_q;
  assign px.win_last  = win_last_q;
  assign px.busy      = (state_q == RUN);

endmodule

`default_nettype wire

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: directed scenarios plus random traffic against an
// image-array reference model of the window generator.
`default_nettype none

module tb_conv_window_gen;
  import conv_pkg::*;

  localparam int W = 4;
  localparam int H = 4;

  logic clk   = 1'b0;
  logic rstn_ = 1'b0;
  always #5 clk = ~clk;

  conv_window_gen_if px ();

  conv_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .rstn_ (rstn_),
    .px    (px)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  bit             m_active;
  int             m_k;
  int             img [H][W];
  logic [WIN_W-1:0] m_win;
  bit             m_vld, m_last;

  int             n_strobe, n_last;
  bit             first_seen;
  logic [WIN_W-1:0] first_win, last_win;

  task automatic check_value(input string tag, input logic [WIN_W-1:0] got,
                             input logic [WIN_W-1:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIN_W-1:0] pack9(input int v0, v1, v2, v3, v4,
                                            v5, v6, v7, v8);
    return {8'(v8), 8'(v7), 8'(v6), 8'(v5), 8'(v4),
            8'(v3), 8'(v2), 8'(v1), 8'(v0)};
  endfunction

  task automatic clear_stats();
    n_strobe   = 0;
    n_last     = 0;
    first_seen = 0;
    first_win  = '0;
    last_win   = '0;
  endtask

  task automatic check_outputs();
    check_value("win_valid", WIN_W'(px.win_valid), WIN_W'(m_vld));
    check_value("win_last",  WIN_W'(px.win_last),  WIN_W'(m_last));
    check_value("busy",      WIN_W'(px.busy),      WIN_W'(m_active));
    check_value("window",    px.window,            m_win);
  endtask

  // One clock: apply inputs, advance model by the frame rules, compare.
  task automatic step(input bit v, input bit s, input logic [7:0] p);
    int r, c;
    px.in_valid = v;
    px.in_sof   = s;
    px.pixel_in = p;
    @(posedge clk);
    m_vld  = 0;
    m_last = 0;
    if (v) begin
      if (s) begin
        m_active = 1;
        m_k      = 0;
      end
      if (m_active) begin
        r = m_k / W;
        c = m_k % W;
        img[r][c] = int'(p);
        if (r >= 2 && c >= 2) begin
          m_vld = 1;
          for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
              m_win[(3*a + b)*8 +: 8] = 8'(img[r-2+a][c-2+b]);
          m_last = (m_k == W*H - 1);
        end
        m_k++;
        if (m_k == W*H) m_active = 0;
      end
    end
    #1;
    check_outputs();
    if (px.win_valid === 1'b1) begin
      n_strobe++;
      last_win = px.window;
      if (!first_seen) begin
        first_seen = 1;
        first_win  = px.window;
      end
    end
    if (px.win_last === 1'b1) n_last++;
  endtask

  task automatic send_frame(input int base, input int gap_mode);
    for (int k = 0; k < W*H; k++) begin
      step(1'b1, k == 0, 8'(base + k + 1));
      if (gap_mode == 1) step(1'b0, 1'b0, 8'($urandom));
      if (gap_mode == 2 && $urandom_range(0, 2) == 0)
        step(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
    end
  endtask

  task automatic do_reset();
    rstn_       = 1'b0;
    px.in_valid = 1'b0;
    px.in_sof   = 1'b0;
    m_active = 0;
    m_k      = 0;
    m_win    = '0;
    m_vld    = 0;
    m_last   = 0;
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    rstn_ = 1'b1;
  endtask

  initial begin
    px.in_valid = 1'b0;
    px.in_sof   = 1'b0;
    px.pixel_in = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = 0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Continuous frame 1..16
    clear_stats();
    send_frame(0, 0);
    check_value("s1_strobes", WIN_W'(n_strobe), WIN_W'(4));
    check_value("s1_first", first_win, pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
    check_value("s1_last", last_win, pack9(6, 7, 8, 10, 11, 12, 14, 15, 16));
    check_value("s1_lastcnt", WIN_W'(n_last), WIN_W'(1));

    // Alternating valid
    clear_stats();
    send_frame(0, 1);
    check_value("s2_strobes", WIN_W'(n_strobe), WIN_W'(4));
    check_value("s2_first", first_win, pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));
    check_value("s2_last", last_win, pack9(6, 7, 8, 10, 11, 12, 14, 15, 16));

    // Pixels before any sof are dropped
    clear_stats();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(200 + i));
    check_value("s3_nowin", WIN_W'(n_strobe), WIN_W'(0));
    send_frame(0, 0);
    check_value("s3_strobes", WIN_W'(n_strobe), WIN_W'(4));
    check_value("s3_first", first_win, pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));

    // Restart at pixel 7
    clear_stats();
    for (int i = 0; i < 6; i++) step(1'b1, i == 0, 8'(i + 1));
    send_frame(100, 0);
    check_value("s4_strobes", WIN_W'(n_strobe), WIN_W'(4));
    check_value("s4_first", first_win,
                pack9(101, 102, 103, 105, 106, 107, 109, 110, 111));

    // Reset mid row 2, then dropped pixels, then a clean frame
    for (int i = 0; i < 9; i++) step(1'b1, i == 0, 8'(i + 1));
    do_reset();
    clear_stats();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(50 + i));
    send_frame(0, 0);
    check_value("s5_strobes", WIN_W'(n_strobe), WIN_W'(4));
    check_value("s5_first", first_win, pack9(1, 2, 3, 5, 6, 7, 9, 10, 11));

    // Back-to-back frames
    clear_stats();
    send_frame(0, 0);
    send_frame(0, 0);
    check_value("s6_strobes", WIN_W'(n_strobe), WIN_W'(8));
    check_value("s6_lastcnt", WIN_W'(n_last), WIN_W'(2));

    // Random traffic: frames with gaps, stray pixels and stray sofs
    for (int f = 0; f < 20; f++) begin
      send_frame(int'($urandom_range(0, 200)), 2);
      for (int i = 0; i < int'($urandom_range(0, 30)); i++)
        step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0),
             8'($urandom));
      if (f == 10) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire
